// File: rtl/ce_gen_pkg.sv
// Shared constants and helpers for the multi-channel fractional clock-enable
// generator (ce_gen_multi). Optional per-channel pulse counters are enabled
// with the CE_GEN_CNT_EN macro.
package ce_gen_pkg;

  // Width of the optional per-channel CE pulse counter.
  localparam int CE_GEN_CNT_W = 16;

  // Widest ratio term the validity helper accepts.
  localparam int CE_GEN_MAX_W = 64;

  // Ratio loaded at reset: IN=1, OUT=0 is a valid ratio that never fires.
  localparam int CE_GEN_RST_IN  = 1;
  localparam int CE_GEN_RST_OUT = 0;

  // A ratio is usable when the denominator is non-zero and OUT <= IN
  // (at most one CE per clock).
  function automatic logic ce_gen_ratio_valid(input logic [CE_GEN_MAX_W-1:0] in_v,
                                              input logic [CE_GEN_MAX_W-1:0] out_v);
    return (in_v != '0) && (out_v <= in_v);
  endfunction

endpackage

// File: rtl/ce_gen_chan.sv
// One channel of ce_gen_multi: ratio registers, Bresenham accumulator,
// registered CE/ERR, and (with CE_GEN_CNT_EN) a 16-bit wrapping CE counter.
// W must not exceed 64.
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    we_i,
  input  logic [W-1:0]            in_i,
  input  logic [W-1:0]            out_i,
  input  logic                    en_i,
  input  logic                    sync_i,
`ifdef CE_GEN_CNT_EN
  output logic [CE_GEN_CNT_W-1:0] cnt_o,
`endif
  output logic                    ce_o,
  output logic                    err_o
);

  logic [W-1:0] cfg_in_q, cfg_in_d;
  logic [W-1:0] cfg_out_q, cfg_out_d;
  // One extra bit so acc + cfg_out never wraps (acc < cfg_in <= 2^W-1).
  logic [W:0]   acc_q, acc_d;
  logic [W:0]   sum;
  logic         ce_q, ce_d;
  logic         err_q, err_d;
  logic         cur_valid;

  assign cur_valid = ce_gen_ratio_valid(CE_GEN_MAX_W'(cfg_in_q), CE_GEN_MAX_W'(cfg_out_q));
  assign sum       = acc_q + {1'b0, cfg_out_q};

  // Next-state: a write or sync restarts the phase; otherwise step the accumulator when enabled.
  always_comb begin
    cfg_in_d  = cfg_in_q;
    cfg_out_d = cfg_out_q;
    acc_d     = acc_q;
    ce_d      = 1'b0;
    if (we_i) begin
      cfg_in_d  = in_i;
      cfg_out_d = out_i;
      acc_d     = '0;
    end else if (sync_i || !cur_valid) begin
      acc_d = '0;
    end else if (en_i) begin
      if (sum >= {1'b0, cfg_in_q}) begin
        acc_d = sum - {1'b0, cfg_in_q};
        ce_d  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
    // ERR always reflects the ratio that will be held after this edge.
    err_d = !ce_gen_ratio_valid(CE_GEN_MAX_W'(cfg_in_d), CE_GEN_MAX_W'(cfg_out_d));
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cfg_in_q  <= W'(CE_GEN_RST_IN);
      cfg_out_q <= W'(CE_GEN_RST_OUT);
      acc_q     <= '0;
      ce_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cfg_in_q  <= cfg_in_d;
      cfg_out_q <= cfg_out_d;
      acc_q     <= acc_d;
      ce_q      <= ce_d;
      err_q     <= err_d;
    end
  end

  assign ce_o  = ce_q;
  assign err_o = err_q;

`ifdef CE_GEN_CNT_EN
  logic [CE_GEN_CNT_W-1:0] cnt_q, cnt_d;

  // Counter next-state: restart with the phase, otherwise count CE decisions.
  always_comb begin
    cnt_d = cnt_q;
    if (we_i || sync_i) begin
      cnt_d = '0;
    end else if (ce_d) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulse counter register, wraps naturally at 0xFFFF.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/ce_gen_multi.sv
// Multi-channel fractional clock-enable generator. Decodes the ratio write
// strobe to one channel and fans SYNC out to all channels. The CNT port and
// counters exist only when CE_GEN_CNT_EN is defined.
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 32,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CFG_WE,
  input  logic [CHW-1:0]           CFG_CH,
  input  logic [W-1:0]             CFG_IN,
  input  logic [W-1:0]             CFG_OUT,
  input  logic [CH-1:0]            EN,
  input  logic                     SYNC,
`ifdef CE_GEN_CNT_EN
  output logic [CH*CE_GEN_CNT_W-1:0] CNT,
`endif
  output logic [CH-1:0]            CE,
  output logic [CH-1:0]            ERR
);

  logic [CH-1:0] we_ch;

  for (genvar n = 0; n < CH; n++) begin : g_chan
    // Addresses at or beyond CH never match, so such writes are dropped.
    assign we_ch[n] = CFG_WE && (CFG_CH == CHW'(n));

    ce_gen_chan #(.W(W)) u_chan (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .we_i    (we_ch[n]),
      .in_i    (CFG_IN),
      .out_i   (CFG_OUT),
      .en_i    (EN[n]),
      .sync_i  (SYNC),
`ifdef CE_GEN_CNT_EN
      .cnt_o   (CNT[n*CE_GEN_CNT_W +: CE_GEN_CNT_W]),
`endif
      .ce_o    (CE[n]),
      .err_o   (ERR[n])
    );
  end

endmodule

// File: tb/tb_ce_gen_multi.sv
// Directed + randomized bench for ce_gen_multi (CH=4, W=32). The reference
// model counts enabled edges n since the last phase restart and fires CE when
// floor(n*OUT/IN) advances.
module tb_ce_gen_multi;

  localparam int CH = 4;
  localparam int W  = 32;

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          RST_N;
  logic          CFG_WE;
  logic [1:0]    CFG_CH;
  logic [W-1:0]  CFG_IN, CFG_OUT;
  logic [CH-1:0] EN;
  logic          SYNC;
  logic [CH-1:0] CE, ERR;
`ifdef CE_GEN_CNT_EN
  logic [CH*16-1:0] CNT;
`endif

  always #5 CLK = ~CLK;

  ce_gen_multi #(.CH(CH), .W(W)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .CFG_WE  (CFG_WE),
    .CFG_CH  (CFG_CH),
    .CFG_IN  (CFG_IN),
    .CFG_OUT (CFG_OUT),
    .EN      (EN),
    .SYNC    (SYNC),
`ifdef CE_GEN_CNT_EN
    .CNT     (CNT),
`endif
    .CE      (CE),
    .ERR     (ERR)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;

  longint unsigned m_in [CH];
  longint unsigned m_out[CH];
  longint unsigned m_n  [CH];
  logic [CH-1:0]   m_ce;
  int unsigned     m_cnt[CH];
  int              pulses[CH];
  logic [CH-1:0]   exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_valid(input int c);
    return (m_in[c] != 0) && (m_out[c] <= m_in[c]);
  endfunction

  function automatic logic [CH-1:0] m_err();
    logic [CH-1:0] e;
    for (int c = 0; c < CH; c++) e[c] = !m_valid(c);
    return e;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      m_in[c] = 1; m_out[c] = 0; m_n[c] = 0; m_cnt[c] = 0;
    end
    m_ce = '0;
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic m_edge();
    for (int c = 0; c < CH; c++) begin
      m_ce[c] = 1'b0;
      if (CFG_WE && CFG_CH == 2'(c)) begin
        m_in[c] = CFG_IN; m_out[c] = CFG_OUT; m_n[c] = 0; m_cnt[c] = 0;
      end else if (SYNC) begin
        m_n[c] = 0; m_cnt[c] = 0;
      end else if (!m_valid(c)) begin
        m_n[c] = 0;
      end else if (EN[c]) begin
        m_n[c]++;
        m_ce[c] = ((m_n[c] * m_out[c]) / m_in[c]) != (((m_n[c] - 1) * m_out[c]) / m_in[c]);
        if (m_ce[c]) m_cnt[c] = (m_cnt[c] + 1) % 65536;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model advances on the edge, outputs checked 1ns later,
  // single-cycle strobes are dropped so the caller can drive the next cycle.
  task automatic tick();
    @(posedge CLK);
    if (RST_N) m_edge();
    exp_q.push_back(m_ce);
    #1;
    chk("ce", 64'(CE), 64'(exp_q.pop_front()));
    chk("err", 64'(ERR), 64'(m_err()));
`ifdef CE_GEN_CNT_EN
    for (int c = 0; c < CH; c++) chk("cnt", 64'(CNT[c*16 +: 16]), 64'(m_cnt[c]));
`endif
    for (int c = 0; c < CH; c++) if (CE[c]) pulses[c]++;
    CFG_WE = 1'b0;
    SYNC   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int ch, input logic [W-1:0] in_v, input logic [W-1:0] out_v);
    CFG_WE = 1'b1; CFG_CH = 2'(ch); CFG_IN = in_v; CFG_OUT = out_v;
  endtask

  task automatic clr_pulses();
    for (int c = 0; c < CH; c++) pulses[c] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_IN = '0; CFG_OUT = '0;
    EN = '0; SYNC = 1'b0;
    m_reset();
    clr_pulses();

    // Reset state.
    run(3);
    chk("rst_ce", 64'(CE), 64'(0));
    chk("rst_err", 64'(ERR), 64'(0));
    RST_N = 1'b1;
    EN = 4'hF;
    run(2);

    // ch0 IN=3 OUT=1: CE visible after edges 3, 6, 9, ...
    wr(0, 3, 1);
    tick();
    clr_pulses();
    run(2);
    chk("ch0_e2", 64'(CE[0]), 64'(0));
    tick();
    chk("ch0_e3", 64'(CE[0]), 64'(1));
    run(27);
    chk("ch0_cnt30", 64'(pulses[0]), 64'(10));
    chk("ch0_err", 64'(ERR[0]), 64'(0));

    // ch1 NTSC-style 6:1 ratio for 6000 cycles.
    wr(1, 32'd21477270, 32'd3579545);
    tick();
    clr_pulses();
    run(6000);
    chk("ch1_6to1", 64'(pulses[1]), 64'(1000));

    // ch1 full-scale IN=OUT: every cycle, no wrap.
    wr(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    clr_pulses();
    run(20);
    chk("ch1_full", 64'(pulses[1]), 64'(20));

    // ch2 5:2 with a 7-cycle pause in the middle.
    wr(2, 5, 2);
    tick();
    clr_pulses();
    run(10);
    EN[2] = 1'b0;
    run(7);
    chk("ch2_pre_pause", 64'(pulses[2]), 64'(4));
    EN[2] = 1'b1;
    run(10);
    chk("ch2_total", 64'(pulses[2]), 64'(8));

    // ch3 invalid ratios then IN=OUT=4.
    wr(3, 0, 1);
    tick();
    chk("ch3_in0_err", 64'(ERR[3]), 64'(1));
    run(5);
    wr(3, 4, 5);
    tick();
    chk("ch3_gt_err", 64'(ERR[3]), 64'(1));
    wr(3, 4, 4);
    tick();
    chk("ch3_ok_err", 64'(ERR[3]), 64'(0));
    clr_pulses();
    run(8);
    chk("ch3_every", 64'(pulses[3]), 64'(8));

    // SYNC with simultaneous write to ch1.
    wr(0, 3, 1); tick();
    wr(1, 11, 4); tick();
    wr(2, 7, 3); tick();
    run(17);
    SYNC = 1'b1;
    wr(1, 7, 2);
    tick();
    chk("sync_ce", 64'(CE), 64'(0));
    run(3);
    chk("sync_ch0_e3", 64'(CE[0]), 64'(1));
    chk("sync_ch1_e3", 64'(CE[1]), 64'(0));
    tick();
    chk("sync_ch1_e4", 64'(CE[1]), 64'(1));
    run(20);

    // Randomized traffic: ratios (some invalid), EN toggling, occasional SYNC.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 9) == 0)
          wr($urandom_range(0, 3), $urandom, $urandom);
        else
          wr($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14));
      end
      if ($urandom_range(0, 99) == 0) SYNC = 1'b1;
      if ($urandom_range(0, 7) == 0) EN = 4'($urandom_range(0, 15));
      tick();
    end

    // Asynchronous reset mid-cycle.
    EN = 4'hF;
    wr(3, 4, 4); tick();
    wr(0, 0, 0); tick();
    run(2);
    chk("pre_rst_ce3", 64'(CE[3]), 64'(1));
    chk("pre_rst_err0", 64'(ERR[0]), 64'(1));
    #3;
    RST_N = 1'b0;
    m_reset();
    #1;
    chk("async_ce", 64'(CE), 64'(0));
    chk("async_err", 64'(ERR), 64'(0));
`ifdef CE_GEN_CNT_EN
    chk("async_cnt", 64'(CNT), 64'(0));
`endif
    run(2);
    RST_N = 1'b1;
    run(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
